phy_tx_striper: RTL
===================

# phy_tx_striper

Parametrised transmit byte-striping stage for the PCI physical-layer TX path. Accepts parallel words from the link side, buffers them in a small FIFO and distributes their bytes MSB-first across `NUM_LANES` byte lanes, one beat per clock. When no word is in flight it drives an idle symbol. It generalises the fixed two-lane, 32-bit split to configurable word width, lane count and buffering, and adds flow control and drop detection.

## Interface

Parameters:
- `WORD_BYTES`, default 4: bytes per input word.
- `NUM_LANES`, default 2: output byte lanes. Must divide `WORD_BYTES`; supported values are 1, 2 and 4.
- `DEPTH`, default 4: FIFO depth in words. Power of two, at least 2.
- Derived `BEATS` = `WORD_BYTES/NUM_LANES`.

Ports:
- `clk_4f` in 1: the single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `active` in 1: link enabled. When low, no new word is started.
- `valid` in 1: `data_input` carries a word this cycle.
- `data_input` in `8*WORD_BYTES`: input word; byte `WORD_BYTES-1` is the MSB.
- `ready` out 1: FIFO not full; combinational, equal to `!full`.
- `data_out` out `8*NUM_LANES`: lane l occupies bits `[8l+7:8l]`.
- `valid_out` out `NUM_LANES`: per-lane data-valid flag. All bits are always equal.
- `fifo_count` out `$clog2(DEPTH)+1`: number of words held.
- `drop_err` out 1: sticky flag; set when a word is dropped.

## Operation

- **Push:** `valid && ready` writes `data_input` into the FIFO.
- **Drop:** `valid && !ready` discards the word and sets `drop_err`. Only `reset` clears `drop_err`.
- **Push when full:** a push is refused while full, even if a pop occurs in the same cycle.
- **State machine:**
  - IDLE: the output registers drive the idle symbol and `valid_out` = 0.
  - IDLE -> SEND when the FIFO is non-empty and `active` = 1. On that edge the head word is popped into a shift register, beat 0 is driven and the beat counter is set to 0.
  - SEND: each edge advances the beat counter and drives the next beat.
  - After beat `BEATS-1`: if the FIFO is non-empty and `active` = 1, the next word is popped and its beat 0 is driven on the following edge, with no bubble. Otherwise the block returns to IDLE.
- **Byte order:** at beat k, lane l carries byte index `WORD_BYTES-1-(k*NUM_LANES+l)`. Lane 0 gets the most significant remaining byte.
- **`active` falling mid-word:** the current word completes all its beats. It is never truncated. Words left in the FIFO stay there.
- **`BEATS` = 1:** the block sits in SEND continuously while words are available.
- **Counters and pointers:** FIFO pointers wrap modulo `DEPTH`. `fifo_count` updates by +1 on push only, -1 on pop only, and holds when both occur.

## Timing

- **Reset** (synchronous, one edge with `reset` = 1): FIFO emptied, `fifo_count` = 0, state = IDLE, `data_out` = idle symbol on every lane, `valid_out` = 0, `drop_err` = 0, `ready` = 1.
- **Reset has priority** over a push or pop in the same cycle. An in-flight word is abandoned and the output is idle immediately after that edge.
- **Latency:** word accepted at edge E0 -> `fifo_count` = 1 after E0 -> popped at E1, with beat 0 visible after E1. Beat k is visible after edge E1+k.
- **Throughput:** one word per `BEATS` cycles when the FIFO is kept non-empty.
- **Registered outputs:** `data_out`, `valid_out`, `fifo_count` and `drop_err`. `ready` is combinational from the FIFO count.

## Configuration

- Macro `PHY_TX_IDLE_COM_EN`:
  - Defined: the idle symbol is 8'hBC (COM) on every lane.
  - Undefined: the idle symbol is 8'h00.
- `valid_out` = 0 during idle in both cases.
- Reset values use the same idle symbol.

## Test plan

- **Single word** (defaults, macro on): push 32'hFFFFEEEE into an idle block with `active` = 1 -> lanes {FF,FF} with `valid_out` = 2'b11 after E1, {EE,EE} after E2, then {BC,BC} with `valid_out` = 0.
- **Back-to-back:** push 32'hAAAA1234 and 32'h12345678 on consecutive cycles -> contiguous beats {AA,AA}, {12,34}, {12,34}, {56,78} with `valid_out` high and no gap.
- **Overflow:** hold `active` = 0 and push 5 words -> `fifo_count` = 4, `ready` = 0, `drop_err` = 1. Then raise `active` -> the first 4 words are emitted in order and `drop_err` stays 1.
- **Active falls mid-word:** drop `active` after beat 0 of 32'hCCEEEEEE with a second word queued -> beat {EE,EE} still emitted, then idle, `fifo_count` = 1.
- **Reset mid-operation:** assert `reset` during beat 0 with 3 words queued -> after that edge `data_out` = {BC,BC}, `valid_out` = 0, `fifo_count` = 0, `drop_err` = 0, `ready` = 1.
- **Lane-count variants:** with `NUM_LANES` = 4, 32'h12345678 appears as lanes 0..3 = 12,34,56,78 in one beat. With `NUM_LANES` = 1 it appears as 12, 34, 56, 78 over 4 beats. With the macro off, idle lanes read 8'h00.

Source files
------------

// File: rtl/phy_tx_striper.sv
// phy_tx_striper: buffers link words in a small FIFO and stripes their bytes MSB-first across NUM_LANES byte lanes.
// Build option: define PHY_TX_IDLE_COM_EN to drive COM (8'hBC) as the idle symbol instead of 8'h00.
module phy_tx_striper #(
    parameter int WORD_BYTES = 4,
    parameter int NUM_LANES  = 2,
    parameter int DEPTH      = 4
) (
    input  logic                      clk_4f,
    input  logic                      reset,
    input  logic                      active,
    input  logic                      valid,
    input  logic [8*WORD_BYTES-1:0]   data_input,
    output logic                      ready,
    output logic [8*NUM_LANES-1:0]    data_out,
    output logic [NUM_LANES-1:0]      valid_out,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      drop_err,
    output logic                      state_dbg
);

    localparam int BEATS  = WORD_BYTES / NUM_LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int LANE_W = 8 * NUM_LANES;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(DEPTH);

`ifdef PHY_TX_IDLE_COM_EN
    localparam logic [7:0] IDLE_SYM = 8'hBC;
`else
    localparam logic [7:0] IDLE_SYM = 8'h00;
`endif
    localparam logic [LANE_W-1:0] IDLE_BEAT = {NUM_LANES{IDLE_SYM}};

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [BEAT_W-1:0]   beat, beat_nxt;
    logic [WORD_W-1:0]   shreg, shreg_nxt;
    logic [LANE_W-1:0]   data_out_nxt;
    logic [NUM_LANES-1:0] valid_out_nxt;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic                full, empty, push, pop, drop, start, load;

    // Lane l takes the byte l positions below the MSB of the (already shifted) word.
    function automatic logic [LANE_W-1:0] lane_map(input logic [WORD_W-1:0] w);
        logic [LANE_W-1:0] r;
        r = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            r[8*l +: 8] = w[WORD_W-8-8*l +: 8];
        end
        return r;
    endfunction

    // valid/ready: a word transfers on an edge where valid && ready; valid with !ready
    // loses the word and latches drop_err. ready depends only on the FIFO count, never on valid.
    assign full      = (fifo_count == FULL_CNT);
    assign empty     = (fifo_count == '0);
    assign ready     = !full;
    assign push      = valid && !full;
    assign drop      = valid && full;
    assign start     = !empty && active;
    assign state_dbg = (state == SEND);

    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat;
        shreg_nxt     = shreg;
        data_out_nxt  = data_out;
        valid_out_nxt = valid_out;
        load          = 1'b0;
        case (state)
            IDLE: begin
                data_out_nxt  = IDLE_BEAT;
                valid_out_nxt = '0;
                load          = start;
            end
            SEND: begin
                if (beat != LAST_BEAT) begin
                    beat_nxt     = beat + BEAT_W'(1);
                    data_out_nxt = lane_map(shreg);
                    shreg_nxt    = shreg << LANE_W;
                end else if (start) begin
                    load = 1'b1;
                end else begin
                    state_nxt     = IDLE;
                    data_out_nxt  = IDLE_BEAT;
                    valid_out_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Popping the head word drives its beat 0 on the same edge, so words chain without a bubble.
        if (load) begin
            state_nxt     = SEND;
            beat_nxt      = '0;
            data_out_nxt  = lane_map(mem[rd_ptr]);
            shreg_nxt     = mem[rd_ptr] << LANE_W;
            valid_out_nxt = '1;
        end
    end

    assign pop = load;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= '0;
            shreg      <= '0;
            data_out   <= IDLE_BEAT;
            valid_out  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat      <= beat_nxt;
            shreg     <= shreg_nxt;
            data_out  <= data_out_nxt;
            valid_out <= valid_out_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                drop_err <= 1'b1;
            end
        end
    end

    // Storage is not reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk_4f) begin
        if (push && !reset) begin
            mem[wr_ptr] <= data_input;
        end
    end

endmodule
